// File: rtl/inst_loader_pkg.sv
//------------------------------------------------------------------------------
// Module   : inst_loader_pkg
// Brief    : Shared constants and state encoding for the instruction loader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package inst_loader_pkg;

    localparam int INST_ADDR_W = 15;

    localparam logic [7:0] c_ack_byte = 8'hAA;
    localparam logic [7:0] c_nak_byte = 8'h55;

    typedef enum logic [1:0] {
        LDR_IDLE = 2'd0,
        LDR_LEN  = 2'd1,
        LDR_DATA = 2'd2,
        LDR_ACK  = 2'd3
    } loader_state_e;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_len  = 2'd1;
    localparam logic [1:0] c_st_data = 2'd2;
    localparam logic [1:0] c_st_ack  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/inst_loader_if.sv
//------------------------------------------------------------------------------
// Module   : inst_loader_if
// Brief    : UART byte stream, instruction RAM write port and ack handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface inst_loader_if #(
    parameter int ADDR_W = 15
);
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        tx_data;

    modport slave (
        input  start, rx_valid, rx_data, tx_ready,
        output mem_we, mem_waddr, mem_wdata, busy, done, err, tx_valid, tx_data
    );

    modport master (
        output start, rx_valid, rx_data, tx_ready,
        input  mem_we, mem_waddr, mem_wdata, busy, done, err, tx_valid, tx_data
    );
endinterface

`default_nettype wire

// File: rtl/inst_loader_byte_assembler.sv
//------------------------------------------------------------------------------
// Module   : inst_loader_byte_assembler
// Brief    : Collects 4 bytes little-endian; word_valid_o flags the 4th byte.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_loader_byte_assembler (
    input  wire logic        clk,
    input  wire logic        rstn,
    input  wire logic        clear_i,
    input  wire logic        byte_valid_i,
    input  wire logic [7:0]  byte_i,
    output logic      [31:0] word_o,
    output logic             word_valid_o
);
    logic [1:0]  cnt_q;
    logic [23:0] shift_q;

    // Only the first three bytes are stored; the 4th is merged combinationally
    // so the full word is available in the same cycle it completes.
    assign word_o       = {byte_i, shift_q};
    assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else if (clear_i) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else if (byte_valid_i) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= {byte_i, shift_q[23:8]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/inst_loader.sv
//------------------------------------------------------------------------------
// Module   : inst_loader
// Brief    : Loads a length-prefixed UART word stream into instruction RAM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int                ADDR_W    = INST_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MAX_WORDS = 32'd32768,
    parameter logic [7:0]        ACK_BYTE  = c_ack_byte,
    parameter logic [7:0]        NAK_BYTE  = c_nak_byte
) (
    input  wire logic    clk,
    input  wire logic    rstn,
    inst_loader_if.slave bus
);
    logic [1:0]        state_q, state_d;
    logic [15:0]       len_q;
    logic [15:0]       idx_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [7:0]        txd_q;

    logic              w_start;
    logic              w_byte_en;
    logic [31:0]       w_word;
    logic              w_word_valid;
    logic              w_len_zero;
    logic              w_len_big;
    logic              w_last;

    assign w_start    = (state_q == c_st_idle) && bus.start;
    assign w_byte_en  = bus.rx_valid && ((state_q == c_st_len) || (state_q == c_st_data));
    assign w_len_zero = (w_word == 32'd0);
    assign w_len_big  = (w_word > MAX_WORDS);
    assign w_last     = (idx_q == (len_q - 16'd1));

    inst_loader_byte_assembler u_asm (
        .clk          (clk),
        .rstn         (rstn),
        .clear_i      (w_start),
        .byte_valid_i (w_byte_en),
        .byte_i       (bus.rx_data),
        .word_o       (w_word),
        .word_valid_o (w_word_valid)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: if (bus.start) state_d = c_st_len;
            c_st_len: begin
                if (w_word_valid) begin
                    if (w_len_zero || w_len_big) state_d = c_st_ack;
                    else                         state_d = c_st_data;
                end
            end
            c_st_data: if (w_word_valid && w_last) state_d = c_st_ack;
            c_st_ack:  if (bus.tx_ready) state_d = c_st_idle;
            default:   state_d = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= c_st_idle;
            len_q   <= 16'd0;
            idx_q   <= 16'd0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            txd_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            we_q    <= 1'b0;
            if (w_start) begin
                err_q <= 1'b0;
                len_q <= 16'd0;
                idx_q <= 16'd0;
            end
            if ((state_q == c_st_len) && w_word_valid) begin
                len_q <= w_word[15:0];
                if (w_len_zero) begin
                    txd_q <= ACK_BYTE;
                end else if (w_len_big) begin
                    txd_q <= NAK_BYTE;
                    err_q <= 1'b1;
                end
            end
            // The write lands one cycle after the word's 4th byte.
            if ((state_q == c_st_data) && w_word_valid) begin
                we_q    <= 1'b1;
                waddr_q <= BASE_ADDR + idx_q[ADDR_W-1:0];
                wdata_q <= w_word;
                idx_q   <= idx_q + 16'd1;
                if (w_last) txd_q <= ACK_BYTE;
            end
        end
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_waddr = waddr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = (state_q != c_st_idle);
    assign bus.err       = err_q;
    assign bus.tx_valid  = (state_q == c_st_ack);
    assign bus.tx_data   = txd_q;
    assign bus.done      = (state_q == c_st_ack) && bus.tx_ready && (txd_q == ACK_BYTE);

endmodule

`default_nettype wire

// File: tb/tb_inst_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_inst_loader
// Brief    : Directed bench for inst_loader at two base addresses with a model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_inst_loader;
    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_ready;

    always #5 clk = ~clk;

    inst_loader_if #(.ADDR_W(15)) if0 ();
    inst_loader_if #(.ADDR_W(15)) if1 ();

    assign if0.start    = start;
    assign if0.rx_valid = rx_valid;
    assign if0.rx_data  = rx_data;
    assign if0.tx_ready = tx_ready;
    assign if1.start    = start;
    assign if1.rx_valid = rx_valid;
    assign if1.rx_data  = rx_data;
    assign if1.tx_ready = tx_ready;

    inst_loader #(.ADDR_W(15), .BASE_ADDR(15'h0000)) dut0 (.clk(clk), .rstn(rstn), .bus(if0.slave));
    inst_loader #(.ADDR_W(15), .BASE_ADDR(15'h0100)) dut1 (.clk(clk), .rstn(rstn), .bus(if1.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 receiving bytes, 2 waiting for ack handshake.
    int          m_phase = 0;
    int          m_cnt   = 0;
    int          m_k     = 0;
    logic [31:0] m_word  = 0;
    logic [31:0] m_n     = 0;
    logic [31:0] m_data  = 0;
    logic        m_we    = 0;
    logic        m_err   = 0;
    logic [7:0]  m_txd   = 0;
    bit          m_valid = 0;

    always @(posedge clk) begin
        m_valid = 1;
        if (!rstn) begin
            m_phase = 0; m_cnt = 0; m_word = 0; m_we = 0; m_err = 0; m_txd = 0;
        end else begin
            m_we = 0;
            case (m_phase)
                0: if (start) begin m_phase = 1; m_cnt = 0; m_err = 0; end
                1: if (rx_valid) begin
                    m_word[8*(m_cnt%4) +: 8] = rx_data;
                    m_cnt++;
                    if (m_cnt == 4) begin
                        m_n = m_word;
                        if (m_n == 0) begin
                            m_phase = 2; m_txd = 8'hAA;
                        end else if (m_n > 32'd32768) begin
                            m_phase = 2; m_txd = 8'h55; m_err = 1;
                        end
                    end else if (m_cnt % 4 == 0) begin
                        m_k    = m_cnt / 4 - 2;
                        m_we   = 1;
                        m_data = m_word;
                        if (m_k == int'(m_n) - 1) begin m_phase = 2; m_txd = 8'hAA; end
                    end
                end
                2: if (tx_ready) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    task automatic cmp_dut(input string tag, input logic we, input logic [14:0] addr,
                           input logic [31:0] data, input logic busy, input logic done,
                           input logic err, input logic txv, input logic [7:0] txd,
                           input logic [14:0] base);
        chk({tag, "_we"},   we,   m_we);
        chk({tag, "_busy"}, busy, m_phase != 0);
        chk({tag, "_err"},  err,  m_err);
        chk({tag, "_txv"},  txv,  m_phase == 2);
        chk({tag, "_done"}, done, (m_phase == 2) && tx_ready && (m_txd == 8'hAA));
        if (m_phase == 2) chk({tag, "_txd"}, txd, m_txd);
        if (m_we) begin
            chk({tag, "_addr"}, addr, 15'(base + 15'(m_k)));
            chk({tag, "_data"}, data, m_data);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            cmp_dut("d0", if0.mem_we, if0.mem_waddr, if0.mem_wdata, if0.busy, if0.done,
                    if0.err, if0.tx_valid, if0.tx_data, 15'h0000);
            cmp_dut("d1", if1.mem_we, if1.mem_waddr, if1.mem_wdata, if1.busy, if1.done,
                    if1.err, if1.tx_valid, if1.tx_data, 15'h0100);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input logic st);
        rx_valid = 1'b1;
        rx_data  = b;
        start    = st;
        tick();
        rx_valid = 1'b0;
        start    = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send4(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], (i == 3) ? 0 : gap, 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_txv();
        for (int i = 0; i < 40 && !if0.tx_valid; i++) tick();
        chk("txv_timeout", if0.tx_valid, 1'b1);
    endtask

    task automatic handshake(input int delay, input logic exp_done);
        repeat (delay) tick();
        tx_ready = 1'b1;
        @(negedge clk);
        chk("hs_done", if0.done, exp_done);
        tick();
        tx_ready = 1'b0;
        @(negedge clk);
        chk("hs_busy_low", if0.busy, 1'b0);
        tick();
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; tx_ready = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_we", if0.mem_we, 1'b0);
        chk("rst_busy", if0.busy, 1'b0);
        chk("rst_txd", if0.tx_data, 8'h00);
        tick();
        rstn = 1'b1;
        send4(32'h0000_0002, 1);
        @(negedge clk);
        chk("idle_busy", if0.busy, 1'b0);
        tick();

        // Two-word load
        pulse_start();
        @(negedge clk);
        chk("start_busy", if0.busy, 1'b1);
        tick();
        send4(32'h0000_0002, 1);
        send4(32'h0010_0513, 1);
        @(negedge clk);
        chk("w0_we", if0.mem_we, 1'b1);
        chk("w0_addr", if0.mem_waddr, 15'h0000);
        chk("w0_data", if0.mem_wdata, 32'h0010_0513);
        tick();
        send4(32'h0000_006F, 1);
        @(negedge clk);
        chk("w1_we", if0.mem_we, 1'b1);
        chk("w1_addr", if0.mem_waddr, 15'h0001);
        chk("w1_data", if0.mem_wdata, 32'h0000_006F);
        chk("w1_txv", if0.tx_valid, 1'b1);
        tick();
        wait_txv();
        chk("two_txd", if0.tx_data, 8'hAA);
        handshake(3, 1'b1);

        // Zero length
        pulse_start();
        send4(32'h0000_0000, 0);
        wait_txv();
        chk("zero_txd", if0.tx_data, 8'hAA);
        handshake(1, 1'b1);

        // Oversize length
        pulse_start();
        send4(32'h0000_8001, 2);
        wait_txv();
        @(negedge clk);
        chk("big_err", if0.err, 1'b1);
        chk("big_txd", if0.tx_data, 8'h55);
        tick();
        handshake(0, 1'b0);
        pulse_start();
        @(negedge clk);
        chk("err_cleared", if0.err, 1'b0);
        tick();
        send4(32'h0000_0000, 0);
        wait_txv();
        handshake(0, 1'b1);

        // Back-to-back bytes, start pulsed mid-DATA
        pulse_start();
        send4(32'h0000_0002, 0);
        send4(32'hDEAD_BEEF, 0);
        @(negedge clk);
        chk("b2b_we", if0.mem_we, 1'b1);
        chk("b2b_data", if0.mem_wdata, 32'hDEAD_BEEF);
        tick();
        send_byte(8'h78, 0, 1'b1);
        send_byte(8'h56, 0, 1'b0);
        send_byte(8'h34, 0, 1'b1);
        send_byte(8'h12, 0, 1'b0);
        @(negedge clk);
        chk("mid_start_addr", if0.mem_waddr, 15'h0001);
        chk("mid_start_data", if0.mem_wdata, 32'h1234_5678);
        tick();
        wait_txv();
        handshake(0, 1'b1);

        // Reset in the middle of a load
        pulse_start();
        send4(32'h0000_0002, 0);
        send_byte(8'h13, 0, 1'b0);
        send_byte(8'h05, 0, 1'b0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("midrst_busy", if0.busy, 1'b0);
        chk("midrst_we", if0.mem_we, 1'b0);
        tick();
        pulse_start();
        send4(32'h0000_0001, 0);
        send4(32'hCAFE_F00D, 0);
        @(negedge clk);
        chk("base_we", if1.mem_we, 1'b1);
        chk("base_addr", if1.mem_waddr, 15'h0100);
        chk("base0_addr", if0.mem_waddr, 15'h0000);
        chk("base_data", if1.mem_wdata, 32'hCAFE_F00D);
        tick();
        wait_txv();
        handshake(0, 1'b1);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
